// File: rtl/im_uart_loader.sv
// UART (8N1) boot loader: receives a word count and big-endian words, writes them
// into instruction memory and holds the core in reset until the image is complete.
module im_uart_loader #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned ADDR_W       = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              RxD,
  output logic              ImWe,
  output logic [ADDR_W-1:0] ImAdr,
  output logic [31:0]       ImData,
  output logic              CpuReset,
  output logic              Busy,
  output logic              Done,
  output logic              FrameErr
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] FullCnt = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfCnt = CntW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {RIdle, RStart, RData, RStop} rx_state_e;
  typedef enum logic [1:0] {LHdr, LLoad, LDone} ld_state_e;

  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e       rx_state_q, rx_state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            byte_valid, frame_err;

  ld_state_e         ld_state_q, ld_state_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [31:0]       data_q, data_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic              we_q, we_d;
  logic              ferr_q, ferr_d;

  // Idle-high synchronizer; rx_prev_q gives the falling-edge detector.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= RxD;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      rx_state_q <= RIdle;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    unique case (rx_state_q)
      RIdle: begin
        if (rx_prev_q && !rx_sync_q) begin
          cnt_d      = HalfCnt;
          rx_state_d = RStart;
        end
      end
      RStart: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
        end else if (rx_sync_q) begin
          rx_state_d = RIdle;
        end else begin
          cnt_d      = FullCnt;
          bit_idx_d  = '0;
          rx_state_d = RData;
        end
      end
      RData: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
        end else begin
          shift_d = {rx_sync_q, shift_q[7:1]};
          cnt_d   = FullCnt;
          if (bit_idx_q == 3'd7) rx_state_d = RStop;
          else                   bit_idx_d  = bit_idx_q + 3'd1;
        end
      end
      RStop: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
        end else begin
          byte_valid = rx_sync_q;
          frame_err  = !rx_sync_q;
          rx_state_d = RIdle;
        end
      end
      default: rx_state_d = RIdle;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      ld_state_q <= LHdr;
      byte_idx_q <= '0;
      data_q     <= '0;
      adr_q      <= '0;
      last_q     <= '0;
      we_q       <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      ld_state_q <= ld_state_d;
      byte_idx_q <= byte_idx_d;
      data_q     <= data_d;
      adr_q      <= adr_d;
      last_q     <= last_d;
      we_q       <= we_d;
      ferr_q     <= ferr_d;
    end
  end

  always_comb begin
    ld_state_d = ld_state_q;
    byte_idx_d = byte_idx_q;
    data_d     = data_q;
    adr_d      = adr_q;
    last_d     = last_q;
    we_d       = 1'b0;
    ferr_d     = ferr_q;
    unique case (ld_state_q)
      LHdr: begin
        if (frame_err) begin
          ferr_d = 1'b1;
        end else if (byte_valid) begin
          // A count of 0 wraps to the all-ones last address, i.e. a full memory.
          last_d     = ADDR_W'(shift_q) - ADDR_W'(1);
          ferr_d     = 1'b0;
          byte_idx_d = '0;
          data_d     = '0;
          adr_d      = '0;
          ld_state_d = LLoad;
        end
      end
      LLoad: begin
        if (frame_err) begin
          ferr_d     = 1'b1;
          byte_idx_d = '0;
          data_d     = '0;
          adr_d      = '0;
          ld_state_d = LHdr;
        end else if (we_q) begin
          // Address advances only after the write strobe has been seen.
          if (adr_q == last_q) ld_state_d = LDone;
          else                 adr_d      = adr_q + ADDR_W'(1);
        end else if (byte_valid) begin
          data_d     = {data_q[23:0], shift_q};
          byte_idx_d = byte_idx_q + 2'd1;
          we_d       = (byte_idx_q == 2'd3);
        end
      end
      LDone: ;
      default: ld_state_d = LHdr;
    endcase
  end

  assign ImWe     = we_q;
  assign ImAdr    = adr_q;
  assign ImData   = data_q;
  assign Busy     = (ld_state_q == LLoad);
  assign Done     = (ld_state_q == LDone);
  assign CpuReset = (ld_state_q != LDone);
  assign FrameErr = ferr_q;

endmodule

// File: tb/tb_im_uart_loader.sv
// Randomized bench for im_uart_loader: drives UART frames and checks memory writes
// and status against a byte-level model of the loader protocol.
module tb_im_uart_loader;

  localparam int Cpb = 6;
  localparam int Aw  = 8;

  logic          Clk = 1'b0;
  logic          Reset = 1'b0;
  logic          RxD = 1'b1;
  logic          ImWe, CpuReset, Busy, Done, FrameErr;
  logic [Aw-1:0] ImAdr;
  logic [31:0]   ImData;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_we_cyc = -10;
  int done_rise_cyc = -20;
  logic done_prev = 1'b0;
  logic [39:0] got_q[$];
  logic [39:0] exp_q[$];

  // Model state, kept per byte rather than per clock
  bit m_loading, m_done, m_ferr;
  int m_n, m_words, m_nbytes, m_adr;
  logic [31:0] m_word;

  always #5 Clk = ~Clk;

  im_uart_loader #(.CLKS_PER_BIT(Cpb), .ADDR_W(Aw)) dut (
    .Clk(Clk), .Reset(Reset), .RxD(RxD), .ImWe(ImWe), .ImAdr(ImAdr), .ImData(ImData),
    .CpuReset(CpuReset), .Busy(Busy), .Done(Done), .FrameErr(FrameErr)
  );

  always @(negedge Clk) begin
    cyc++;
    if (ImWe) begin
      got_q.push_back({ImAdr, ImData});
      last_we_cyc = cyc;
    end
    if (Done && !done_prev) done_rise_cyc = cyc;
    done_prev = Done;
  end

  task automatic model_reset();
    m_loading = 0; m_done = 0; m_ferr = 0;
    m_n = 0; m_words = 0; m_nbytes = 0; m_adr = 0; m_word = 0;
    exp_q.delete();
  endtask

  task automatic model_byte(input logic [7:0] b, input bit ok);
    if (m_done) return;
    if (!ok) begin
      m_ferr = 1; m_loading = 0; m_nbytes = 0; m_word = 0; m_adr = 0;
      return;
    end
    if (!m_loading) begin
      m_n = (b == 0) ? 256 : int'(b);
      m_loading = 1; m_ferr = 0; m_words = 0; m_nbytes = 0; m_word = 0; m_adr = 0;
    end else begin
      m_word = (m_word << 8) | 32'(b);
      m_nbytes++;
      if (m_nbytes == 4) begin
        exp_q.push_back({8'(m_words), m_word});
        m_words++;
        m_nbytes = 0;
        m_word = 0;
        if (m_words == m_n) begin
          m_done = 1;
          m_adr = m_n - 1;
        end else begin
          m_adr = m_words;
        end
      end
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit ok, input int gap);
    model_byte(b, ok);
    RxD = 1'b0;
    cycles(Cpb);
    for (int i = 0; i < 8; i++) begin
      RxD = b[i];
      cycles(Cpb);
    end
    RxD = ok;
    cycles(Cpb);
    RxD = 1'b1;
    cycles(gap + (ok ? 0 : Cpb));
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b1, int'($urandom_range(1, 4)));
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    RxD = 1'b1;
    cycles(3);
    Reset = 1'b1;
    cycles(3);
    model_reset();
    got_q.delete();
    last_we_cyc = -10;
    done_rise_cyc = -20;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    RxD = 1'b1;
    cycles(4);
    checks++;
    if (ImWe !== 1'b0 || ImAdr !== '0 || ImData !== 32'h0) begin
      failures++;
      $display("FAIL reset_mem got we=%b adr=%h data=%h exp we=0 adr=00 data=00000000",
               ImWe, ImAdr, ImData);
    end
    checks++;
    if ({CpuReset, Busy, Done, FrameErr} !== 4'b1000) begin
      failures++;
      $display("FAIL reset_status got cpu/busy/done/ferr=%b exp=1000",
               {CpuReset, Busy, Done, FrameErr});
    end
    do_reset();
  endtask

  task automatic test_two_word();
    logic [11:0] st_exp;
    send_byte(8'h02);
    send_word(32'h20080005);
    send_word(32'hAC080000);
    cycles(4);
    checks++;
    if (got_q.size() != 2) begin
      failures++;
      $display("FAIL two_word_count got=%0d exp=2", got_q.size());
    end
    if (got_q.size() >= 1) begin
      checks++;
      if (got_q[0] !== 40'h00_20080005) begin
        failures++;
        $display("FAIL two_word_wr0 got=%h exp=0020080005", got_q[0]);
      end
    end
    if (got_q.size() >= 2) begin
      checks++;
      if (got_q[1] !== 40'h01_AC080000) begin
        failures++;
        $display("FAIL two_word_wr1 got=%h exp=01ac080000", got_q[1]);
      end
    end
    st_exp = {8'(m_adr), m_done, !m_done, m_loading && !m_done, m_ferr};
    checks++;
    if ({ImAdr, Done, CpuReset, Busy, FrameErr} !== st_exp) begin
      failures++;
      $display("FAIL two_word_status got=%h exp=%h",
               {ImAdr, Done, CpuReset, Busy, FrameErr}, st_exp);
    end
    checks++;
    if (done_rise_cyc - last_we_cyc != 1) begin
      failures++;
      $display("FAIL two_word_done_timing got=%0d exp=1", done_rise_cyc - last_we_cyc);
    end
  endtask

  task automatic test_random_load();
    logic [11:0] st_exp;
    int n;
    for (int rep = 0; rep < 3; rep++) begin
      do_reset();
      n = int'($urandom_range(1, 4));
      send_byte(8'(n));
      for (int w = 0; w < n; w++) send_word($urandom);
      cycles(4);
      checks++;
      if (got_q.size() != exp_q.size()) begin
        failures++;
        $display("FAIL rand_load_count got=%0d exp=%0d", got_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) begin
        if (i < got_q.size()) begin
          checks++;
          if (got_q[i] !== exp_q[i]) begin
            failures++;
            $display("FAIL rand_load_wr%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
          end
        end
      end
      st_exp = {8'(m_adr), m_done, !m_done, m_loading && !m_done, m_ferr};
      checks++;
      if ({ImAdr, Done, CpuReset, Busy, FrameErr} !== st_exp) begin
        failures++;
        $display("FAIL rand_load_status got=%h exp=%h",
                 {ImAdr, Done, CpuReset, Busy, FrameErr}, st_exp);
      end
      checks++;
      if (done_rise_cyc - last_we_cyc != 1) begin
        failures++;
        $display("FAIL rand_load_done_timing got=%0d exp=1", done_rise_cyc - last_we_cyc);
      end
    end
  endtask

  task automatic test_full_load();
    logic [11:0] st_exp;
    do_reset();
    send_byte(8'h00);
    for (int w = 0; w < 256; w++) begin
      send_frame(8'h00, 1'b1, 1);
      send_frame(8'h00, 1'b1, 1);
      send_frame(8'h00, 1'b1, 1);
      send_frame(8'(w), 1'b1, 1);
    end
    cycles(4);
    checks++;
    if (got_q.size() != 256) begin
      failures++;
      $display("FAIL full_load_count got=%0d exp=256", got_q.size());
    end
    foreach (exp_q[i]) begin
      if (i < got_q.size()) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL full_load_wr%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
        end
      end
    end
    st_exp = {8'(m_adr), m_done, !m_done, m_loading && !m_done, m_ferr};
    checks++;
    if ({ImAdr, Done, CpuReset, Busy, FrameErr} !== st_exp || ImAdr !== 8'hFF) begin
      failures++;
      $display("FAIL full_load_status got=%h exp=%h",
               {ImAdr, Done, CpuReset, Busy, FrameErr}, st_exp);
    end
  endtask

  task automatic test_frame_err();
    logic [11:0] st_exp;
    do_reset();
    send_byte(8'h02);
    send_word($urandom);
    send_byte(8'h11);
    send_byte(8'h22);
    send_frame(8'h33, 1'b0, 2);
    cycles(4);
    checks++;
    if (got_q.size() != 1 || (got_q.size() == 1 && got_q[0] !== exp_q[0])) begin
      failures++;
      $display("FAIL ferr_writes got=%0d writes exp=1 write %h", got_q.size(), exp_q[0]);
    end
    st_exp = {8'(m_adr), m_done, !m_done, m_loading && !m_done, m_ferr};
    checks++;
    if ({ImAdr, Done, CpuReset, Busy, FrameErr} !== st_exp) begin
      failures++;
      $display("FAIL ferr_status got=%h exp=%h",
               {ImAdr, Done, CpuReset, Busy, FrameErr}, st_exp);
    end
    got_q.delete();
    exp_q.delete();
    send_byte(8'h01);
    st_exp = {8'(m_adr), m_done, !m_done, m_loading && !m_done, m_ferr};
    checks++;
    if ({ImAdr, Done, CpuReset, Busy, FrameErr} !== st_exp) begin
      failures++;
      $display("FAIL ferr_hdr_clear got=%h exp=%h",
               {ImAdr, Done, CpuReset, Busy, FrameErr}, st_exp);
    end
    send_word(32'hDEADBEEF);
    cycles(4);
    checks++;
    if (got_q.size() != 1 || (got_q.size() == 1 && got_q[0] !== 40'h00_DEADBEEF)) begin
      failures++;
      $display("FAIL ferr_reload got=%0d writes exp=1 write 00deadbeef", got_q.size());
    end
    st_exp = {8'(m_adr), m_done, !m_done, m_loading && !m_done, m_ferr};
    checks++;
    if ({ImAdr, Done, CpuReset, Busy, FrameErr} !== st_exp) begin
      failures++;
      $display("FAIL ferr_reload_status got=%h exp=%h",
               {ImAdr, Done, CpuReset, Busy, FrameErr}, st_exp);
    end
  endtask

  task automatic test_glitch_post_done();
    logic [11:0] st_exp;
    logic [31:0] w;
    // Loader is in done state here
    got_q.delete();
    RxD = 1'b0;
    cycles(3);
    RxD = 1'b1;
    cycles(2 * Cpb);
    send_byte(8'($urandom));
    send_frame(8'($urandom), 1'b0, 2);
    send_word($urandom);
    cycles(4);
    checks++;
    if (got_q.size() != 0) begin
      failures++;
      $display("FAIL post_done_writes got=%0d exp=0", got_q.size());
    end
    st_exp = {8'(m_adr), m_done, !m_done, m_loading && !m_done, m_ferr};
    checks++;
    if ({ImAdr, Done, CpuReset, Busy, FrameErr} !== st_exp) begin
      failures++;
      $display("FAIL post_done_status got=%h exp=%h",
               {ImAdr, Done, CpuReset, Busy, FrameErr}, st_exp);
    end
    do_reset();
    RxD = 1'b0;
    cycles(3);
    RxD = 1'b1;
    cycles(2 * Cpb);
    st_exp = {8'(m_adr), m_done, !m_done, m_loading && !m_done, m_ferr};
    checks++;
    if ({ImAdr, Done, CpuReset, Busy, FrameErr} !== st_exp) begin
      failures++;
      $display("FAIL glitch_status got=%h exp=%h",
               {ImAdr, Done, CpuReset, Busy, FrameErr}, st_exp);
    end
    w = $urandom;
    send_byte(8'h01);
    send_word(w);
    cycles(4);
    checks++;
    if (got_q.size() != 1 || (got_q.size() == 1 && got_q[0] !== {8'h00, w})) begin
      failures++;
      $display("FAIL glitch_load got=%0d writes exp=1 write 00%h", got_q.size(), w);
    end
  endtask

  task automatic test_reset_mid_load();
    logic [11:0] st_exp;
    do_reset();
    send_byte(8'h04);
    send_word($urandom);
    send_word($urandom);
    send_byte(8'($urandom));
    RxD = 1'b0;
    cycles(2 * Cpb);
    #2;
    Reset = 1'b0;
    #1;
    checks++;
    if ({ImWe, ImAdr, ImData, CpuReset, Busy, Done, FrameErr} !== {1'b0, 8'h00, 32'h0, 4'b1000}) begin
      failures++;
      $display("FAIL mid_reset_outputs got we=%b adr=%h data=%h cpu/busy/done/ferr=%b exp 0 00 0 1000",
               ImWe, ImAdr, ImData, {CpuReset, Busy, Done, FrameErr});
    end
    checks++;
    if (got_q.size() != 2 || (got_q.size() == 2 && (got_q[0] !== exp_q[0] || got_q[1] !== exp_q[1]))) begin
      failures++;
      $display("FAIL mid_reset_prior_writes got=%0d exp=2", got_q.size());
    end
    RxD = 1'b1;
    cycles(2);
    Reset = 1'b1;
    cycles(2 * Cpb);
    model_reset();
    got_q.delete();
    send_byte(8'h01);
    send_word(32'h00000008);
    cycles(4);
    checks++;
    if (got_q.size() != 1 || (got_q.size() == 1 && got_q[0] !== 40'h00_00000008)) begin
      failures++;
      $display("FAIL mid_reset_reload got=%0d writes exp=1 write 0000000008", got_q.size());
    end
    st_exp = {8'(m_adr), m_done, !m_done, m_loading && !m_done, m_ferr};
    checks++;
    if ({ImAdr, Done, CpuReset, Busy, FrameErr} !== st_exp) begin
      failures++;
      $display("FAIL mid_reset_status got=%h exp=%h",
               {ImAdr, Done, CpuReset, Busy, FrameErr}, st_exp);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_two_word();
    test_random_load();
    test_frame_err();
    test_glitch_post_done();
    test_reset_mid_load();
    test_full_load();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/im_uart_loader.md
# im_uart_loader

Serial boot loader for the single-cycle MIPS core. It receives a program over a UART line (8N1) and writes it word by word into instruction memory through the same 8-bit word-address / 32-bit data port the core reads. While the load is in progress it holds the core in reset. This replaces the simulation-only `$readmemh` image load on the FPGA board.

## Interface
Parameters:
- CLKS_PER_BIT, 868: clock cycles per UART bit (100 MHz / 115200). Must be ≥ 4.
- ADDR_W, 8: instruction-memory word-address width. Capacity is 2^ADDR_W words.

Ports:
- Clk  in  1  system clock; all logic is on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- RxD  in  1  UART receive line; idle high; asynchronous to Clk.
- ImWe  out  1  instruction-memory write strobe; one-cycle pulse per word.
- ImAdr  out  ADDR_W  word address for ImWe.
- ImData  out  32  word to write; valid while ImWe=1.
- CpuReset  out  1  active-high reset to the core (drives the core's PC reset).
- Busy  out  1  header accepted, load in progress.
- Done  out  1  load complete; sticky until Reset.
- FrameErr  out  1  last frame had stop bit = 0; sticky until the next header is accepted.

## Operation
- Reset values: ImWe=0, ImAdr=0, ImData=0, CpuReset=1, Busy=0, Done=0, FrameErr=0. Both FSMs are in idle state.
- RxD passes through a 2-flop synchronizer. All sampling uses the synchronized signal.
- Byte receiver FSM, states R_IDLE → R_START → R_DATA → R_STOP → R_IDLE:
  - R_IDLE: on a synchronized high→low edge, load the bit counter and go to R_START.
  - R_START: wait CLKS_PER_BIT/2 cycles, then re-sample. If the line is high, treat it as a glitch and return to R_IDLE. If low, go to R_DATA.
  - R_DATA: sample every CLKS_PER_BIT cycles, 8 bits, LSB first.
  - R_STOP: sample once after CLKS_PER_BIT cycles.
    - Line = 1: emit a one-cycle byte_valid.
    - Line = 0: emit a one-cycle frame_err. The byte is discarded.
  - Return to R_IDLE immediately after the stop sample (no wait for the full stop bit).
- Loader FSM, states L_HDR → L_LOAD → L_DONE:
  - L_HDR: the first valid byte is the word count N; 0 means 2^ADDR_W. Clear FrameErr, set Busy=1, clear the byte index and ImAdr.
  - L_LOAD: shift bytes into ImData, big-endian (first byte → ImData[31:24]). On the 4th byte, pulse ImWe for one cycle with the current ImAdr.
    - In the cycle after the ImWe pulse, ImAdr increments.
    - On the Nth word, ImAdr does not increment; it holds the last address. The FSM goes to L_DONE.
  - L_DONE: Done=1, Busy=0, CpuReset=0. All further bytes and errors are ignored until Reset.
- Any frame_err in L_HDR or L_LOAD:
  - set FrameErr=1, Busy=0, no ImWe;
  - discard the partial word, ImAdr returns to 0;
  - return to L_HDR; CpuReset stays 1.
- Words already written before an error stay in memory; the host resends the whole image.

## Timing
- Synchronizer latency: 2 cycles from an RxD edge to its internal view.
- byte_valid occurs CLKS_PER_BIT/2 + 9·CLKS_PER_BIT cycles after the synchronized start edge, ±1 cycle.
- ImWe asserts in the cycle after the 4th byte's byte_valid. ImData and ImAdr are stable during that cycle.
- Done rises and CpuReset falls in the cycle after the final ImWe pulse. The core therefore starts fetching at PC 0 with the complete image in memory.
- Words are written at most once per 4 frames. No write backpressure: instruction memory accepts a write every cycle.
- Reset asserted mid-frame or mid-word: all outputs take their reset values asynchronously, and any partial byte or word is lost. Receive resumes on the first falling edge seen after deassertion; a frame already in progress on the line may cause one frame error.

## Test plan
- Reset check: hold Reset=0 with RxD=1 → ImWe=0, ImAdr=0, CpuReset=1, Busy=0, Done=0, FrameErr=0.
- Two-word load: send bytes 02, 20 08 00 05, AC 08 00 00 at CLKS_PER_BIT=16.
  - ImWe pulse at ImAdr=0 with ImData=0x20080005.
  - ImWe pulse at ImAdr=1 with ImData=0xAC080000.
  - Next cycle: Done=1, CpuReset=0, Busy=0.
- Full load: header 00, then 256 words with value = index.
  - 256 ImWe pulses at ImAdr 0x00..0xFF, data matching the index.
  - ImAdr holds 0xFF after the last pulse; Done=1.
- Framing error: header 01, then bytes 11 22 with a stop bit of 0 on the byte 33 frame.
  - FrameErr=1, no ImWe, CpuReset=1.
  - Then send 01 DE AD BE EF → FrameErr clears on the header, ImWe at address 0 with ImData=0xDEADBEEF, Done=1.
- Glitch and post-done: a 3-cycle low pulse on RxD produces no byte and no state change. A valid byte sent after Done=1 causes no ImWe.
- Reset mid-load: assert Reset during the 3rd word of a 4-word load → outputs return to reset values. A new load of 01 00 00 00 08 then writes ImAdr=0 with ImData=0x00000008.
